// File: rtl/vec_loader_x_blk.sv
// vec_loader_x_blk
// Serial-to-parallel loader placed in front of the blocked LSTM vector-matrix
// stage. Each handshake brings in one 16-bit input element and one 16-bit
// weight element. The block assembles vectwidth of each into data_x and W_x.
// It then presents the complete pair with valid/ready and holds it until the
// consumer accepts it. A frame whose length does not match vectwidth sets the
// sticky err_len flag.
//
// Build option:
//   VEC_LOADER_DBUF_EN  defined   : two ping-pong banks, so the block can
//                                   stream with no bubble between frames
//   VEC_LOADER_DBUF_EN  undefined : single buffer with a FILL/FULL FSM
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready  input element handshake (in_ready is registered)
//   in_data_x, in_w_x  input element and weight element
//   in_last            marks the final element of a frame
//   out_valid/out_ready  output vector handshake
//   data_x, W_x        flat buses; element i sits at [16i+15:16i]
//   err_len            sticky frame-length error, cleared only by reset
module vec_loader_x_blk #(
  parameter int varraysize = 1600,
  parameter int vectwidth  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_data_x,
  input  logic [15:0]           in_w_x,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [varraysize-1:0] data_x,
  output logic [varraysize-1:0] W_x,
  output logic                  err_len
);

  localparam int CW = (vectwidth > 1) ? $clog2(vectwidth) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(vectwidth - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          err_len_q, err_len_d;
  logic          accept;
  logic          frame_done;

  assign accept     = in_valid && in_ready_q;
  // A frame completes on the last slot whether or not in_last is set.
  // A long frame is still presented, but it is flagged.
  assign frame_done = accept && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d     = cnt_q;
    err_len_d = err_len_q;
    if (accept) begin
      if (in_last || (cnt_q == LAST_CNT)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Error when in_last is set on any slot but the last one (short frame),
      // or when it is missing on the last slot (long frame).
      if (in_last != (cnt_q == LAST_CNT)) begin
        err_len_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      err_len_q  <= err_len_d;
    end
  end

  assign in_ready = in_ready_q;
  assign err_len  = err_len_q;

`ifdef VEC_LOADER_DBUF_EN

  logic [varraysize-1:0] dbank_q [2];
  logic [varraysize-1:0] dbank_d [2];
  logic [varraysize-1:0] wbank_q [2];
  logic [varraysize-1:0] wbank_d [2];
  logic [1:0]            full_q, full_d;
  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;

  always_comb begin
    dbank_d = dbank_q;
    wbank_d = wbank_q;
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    if (accept) begin
      dbank_d[wb_q][32'(cnt_q) * 16 +: 16] = in_data_x;
      wbank_d[wb_q][32'(cnt_q) * 16 +: 16] = in_w_x;
    end
    if (frame_done) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    // A fill can only target an empty bank, and a drain can only come from a
    // full one. So when both happen on the same edge they touch different
    // banks, and both updates apply.
    if (full_q[rb_q] && out_ready) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
    in_ready_d = !full_d[wb_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        dbank_q[i] <= '0;
        wbank_q[i] <= '0;
      end
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
    end else begin
      dbank_q <= dbank_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
    end
  end

  assign out_valid = full_q[rb_q];
  assign data_x    = dbank_q[rb_q];
  assign W_x       = wbank_q[rb_q];

`else

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [varraysize-1:0] data_q, data_d;
  logic [varraysize-1:0] w_q, w_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    w_d     = w_q;
    case (state_q)
      FILL: if (frame_done) state_d = FULL;
      FULL: if (out_ready)  state_d = FILL;
      default: state_d = FILL;
    endcase
    // Writes land directly in the output register. While the state is FULL,
    // in_ready_q is low, so the presented pair cannot change.
    if (accept) begin
      data_d[32'(cnt_q) * 16 +: 16] = in_data_x;
      w_d[32'(cnt_q) * 16 +: 16]    = in_w_x;
    end
    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      data_q  <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      w_q     <= w_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign data_x    = data_q;
  assign W_x       = w_q;

`endif

endmodule
